// File: rtl/tap_pkg.sv
// TAP state encodings and routing helpers shared by the TMS sequencer
// and the TAP_route benches.
package tap_pkg;

    typedef enum logic [3:0] {
        TAP_EX2DR   = 4'h0,
        TAP_EX1DR   = 4'h1,
        TAP_SHDR    = 4'h2,
        TAP_PAUSEDR = 4'h3,
        TAP_SELIR   = 4'h4,
        TAP_UPDDR   = 4'h5,
        TAP_CAPDR   = 4'h6,
        TAP_SELDR   = 4'h7,
        TAP_EX2IR   = 4'h8,
        TAP_EX1IR   = 4'h9,
        TAP_SHIR    = 4'hA,
        TAP_PAUSEIR = 4'hB,
        TAP_RTI     = 4'hC,
        TAP_UPDIR   = 4'hD,
        TAP_CAPIR   = 4'hE,
        TAP_TLR     = 4'hF
    } tap_state_e;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_SYNC,
        SEQ_WALK,
        SEQ_HOLD,
        SEQ_DONE
    } seq_state_e;

    localparam logic [2:0] SYNC_STEPS = 3'd5;

    function automatic logic [3:0] tap_next(input logic [3:0] s,
                                            input logic tms);
        logic [3:0] n;
        case (s)
            TAP_TLR:     n = tms ? TAP_TLR   : TAP_RTI;
            TAP_RTI:     n = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELDR:   n = tms ? TAP_SELIR : TAP_CAPDR;
            TAP_CAPDR:   n = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_SHDR:    n = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_EX1DR:   n = tms ? TAP_UPDDR : TAP_PAUSEDR;
            TAP_PAUSEDR: n = tms ? TAP_EX2DR : TAP_PAUSEDR;
            TAP_EX2DR:   n = tms ? TAP_UPDDR : TAP_SHDR;
            TAP_UPDDR:   n = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELIR:   n = tms ? TAP_TLR   : TAP_CAPIR;
            TAP_CAPIR:   n = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_SHIR:    n = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_EX1IR:   n = tms ? TAP_UPDIR : TAP_PAUSEIR;
            TAP_PAUSEIR: n = tms ? TAP_EX2IR : TAP_PAUSEIR;
            TAP_EX2IR:   n = tms ? TAP_UPDIR : TAP_SHIR;
            TAP_UPDIR:   n = tms ? TAP_SELDR : TAP_RTI;
            default:     n = TAP_TLR;
        endcase
        return n;
    endfunction

    // Breadth-first step count; unrolls to a constant 16x16 table.
    function automatic logic [2:0] tap_dist(input logic [3:0] cur,
                                            input logic [3:0] tgt);
        logic [15:0] reach;
        logic [15:0] nxt;
        logic [2:0]  d;
        reach = 16'h0001 << cur;
        d = 3'd7;
        for (int k = 0; k < 7; k++) begin
            if (reach[tgt] && d == 3'd7) d = 3'(k);
            nxt = '0;
            for (int i = 0; i < 16; i++) begin
                if (reach[i]) begin
                    nxt[tap_next(4'(i), 1'b0)] = 1'b1;
                    nxt[tap_next(4'(i), 1'b1)] = 1'b1;
                end
            end
            reach = nxt;
        end
        return d;
    endfunction

    // Ties resolve to TMS=0.
    function automatic logic tap_route_tms(input logic [3:0] cur,
                                           input logic [3:0] tgt);
        return tap_dist(tap_next(cur, 1'b0), tgt) >
               tap_dist(tap_next(cur, 1'b1), tgt);
    endfunction

    function automatic logic tap_is_stable(input logic [3:0] s);
        return s inside {TAP_TLR, TAP_RTI, TAP_SHDR, TAP_PAUSEDR,
                         TAP_SHIR, TAP_PAUSEIR};
    endfunction

    function automatic logic tap_hold_tms(input logic [3:0] s);
        return s == TAP_TLR;
    endfunction

endpackage

// File: rtl/tap_step_div.sv
// TAP step divider: one tick every TCK_DIV enabled cycles, restarted by
// clr in the same cycle, plus the registered tck_en strobe.
module tap_step_div #(
    parameter int TCK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick,
    output logic tck_en
);
    localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TCK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_eff;

    always_comb begin
        cnt_eff = clr ? '0 : cnt_q;
        tick    = en && (cnt_eff == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tck_en <= 1'b0;
        end else begin
            tck_en <= tick;
            if (tick)
                cnt_q <= '0;
            else if (en)
                cnt_q <= cnt_eff + CW'(1);
            else
                cnt_q <= cnt_eff;
        end
    end

endmodule

// File: rtl/tap_tms_sequencer.sv
// Command-driven TMS generator: mirrors the TAP state and walks it to a
// target along the shortest path, with optional sync and hold phases.
module tap_tms_sequencer
    import tap_pkg::*;
#(
    parameter int TCK_DIV = 4,
    parameter int CNT_W   = 8
) (
    input  logic             GCLK_Pad,
    input  logic             TRST_Pad,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_target,
    input  logic [CNT_W-1:0] cmd_hold,
    input  logic             cmd_sync,
    output logic             tms_out,
    output logic             tck_en,
    output logic [3:0]       tap_state,
    output logic             busy,
    output logic             done,
    output logic             err
);
    seq_state_e state_q, state_n;
    seq_state_e p0, p1, p2, p3;

    logic [3:0]       mirror_q, mir_p;
    logic [3:0]       target_q, tgt_e;
    logic [CNT_W-1:0] hold_q, hold_e;
    logic [2:0]       sync_q, sync_e;
    logic             force_q, tms_q, err_q;
    logic             accept, need, tick, tck_en_w, step_tms;

    assign cmd_ready = (state_q == SEQ_IDLE) && !TRST_Pad;
    assign accept    = cmd_valid && cmd_ready;

    tap_step_div #(.TCK_DIV(TCK_DIV)) u_div (
        .clk   (GCLK_Pad),
        .rst   (TRST_Pad),
        .clr   (accept),
        .en    (need),
        .tick  (tick),
        .tck_en(tck_en_w)
    );

    // Decisions look at the mirror as it will be after a pending step,
    // so back-to-back steps work at TCK_DIV=1.
    always_comb begin
        mir_p = mirror_q;
        if (tck_en_w)
            mir_p = force_q ? TAP_TLR : tap_next(mirror_q, tms_q);
        p0     = state_q;
        tgt_e  = target_q;
        hold_e = hold_q;
        sync_e = sync_q;
        if (accept) begin
            p0     = cmd_sync ? SEQ_SYNC : SEQ_WALK;
            tgt_e  = cmd_target;
            hold_e = tap_is_stable(cmd_target) ? cmd_hold : '0;
            sync_e = SYNC_STEPS;
        end
        p1 = (p0 == SEQ_SYNC && sync_e == 3'd0) ? SEQ_WALK : p0;
        p2 = p1;
        if (p1 == SEQ_WALK && mir_p == tgt_e)
            p2 = (hold_e != '0) ? SEQ_HOLD : SEQ_DONE;
        p3 = (p2 == SEQ_HOLD && hold_e == '0) ? SEQ_DONE : p2;
        need = p3 inside {SEQ_SYNC, SEQ_WALK, SEQ_HOLD};
        step_tms = 1'b0;
        case (p3)
            SEQ_SYNC: step_tms = 1'b1;
            SEQ_WALK: step_tms = tap_route_tms(mir_p, tgt_e);
            SEQ_HOLD: step_tms = tap_hold_tms(tgt_e);
            default:  step_tms = 1'b0;
        endcase
        // A zero-length command still spends one cycle in WALK.
        if (state_q == SEQ_DONE)
            state_n = SEQ_IDLE;
        else if (accept && p3 == SEQ_DONE)
            state_n = SEQ_WALK;
        else
            state_n = p3;
    end

    always_ff @(posedge GCLK_Pad) begin
        if (TRST_Pad) begin
            state_q  <= SEQ_IDLE;
            mirror_q <= TAP_TLR;
            target_q <= TAP_TLR;
            hold_q   <= '0;
            sync_q   <= '0;
            force_q  <= 1'b0;
            tms_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            mirror_q <= mir_p;
            target_q <= tgt_e;
            hold_q   <= (tick && p3 == SEQ_HOLD) ? hold_e - CNT_W'(1)
                                                 : hold_e;
            sync_q   <= (tick && p3 == SEQ_SYNC) ? sync_e - 3'd1 : sync_e;
            force_q  <= tick && p3 == SEQ_SYNC && sync_e == 3'd1;
            if (tick)
                tms_q <= step_tms;
            err_q    <= accept && !tap_is_stable(cmd_target)
                        && cmd_hold != '0;
        end
    end

    assign tms_out   = tms_q;
    assign tck_en    = tck_en_w;
    assign tap_state = mirror_q;
    assign busy      = state_q != SEQ_IDLE;
    assign done      = state_q == SEQ_DONE;
    assign err       = err_q;

endmodule
